// File: rtl/pipeline_pkg.sv
// Shared encodings for the memory-stage controller: FSM states and access-width codes,
// plus the alignment check used when an access is first seen in EX/MEM.
package pipeline_pkg;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

    localparam logic [1:0] WidthWord    = 2'b00;
    localparam logic [1:0] WidthHalf    = 2'b01;
    localparam logic [1:0] WidthByte    = 2'b10;
    localparam logic [1:0] WidthWordAlt = 2'b11;

    function automatic logic addr_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        unique case (width)
            WidthWord, WidthWordAlt: bad = (addr_lo != 2'b00);
            WidthHalf:               bad = addr_lo[0];
            WidthByte:               bad = 1'b0;
            default:                 bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard check between the load in ID/EX and the sources in IF/ID.
module hazard_detect (
    input  logic       id_ex_mem_to_reg,
    input  logic [4:0] id_ex_write_register,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    output logic       hazard_stall
);

    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    always_comb begin
        hazard_stall = id_ex_mem_to_reg && (id_ex_write_register != 5'd0) &&
                       ((id_ex_write_register == if_id_rs) ||
                        (id_ex_write_register == if_id_rt));
    end

endmodule

// File: rtl/mem_stage_controller.sv
// Sequences the EX/MEM data-memory access over a req/ack port and generates the
// pipeline advance, freeze and flush controls, including load-use hazard handling.
module mem_stage_controller
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       memWrite,
    input  logic             memToReg,
    input  logic [1:0]       memReadWidth,
    input  logic [31:0]      aluOut,
    input  logic [31:0]      writeData,
    input  logic             idExMemToReg,
    input  logic [4:0]       idExWriteRegister,
    input  logic [4:0]       ifIdRs,
    input  logic [4:0]       ifIdRt,
    input  logic             memReady,
    input  logic [31:0]      memRdata,
    output logic             memReq,
    output logic [3:0]       memWe,
    output logic [31:0]      memAddr,
    output logic [31:0]      memWdata,
    output logic [31:0]      loadDataOut,
    output logic             pcWriteEnable,
    output logic             ifIdWriteEnable,
    output logic             exMemWriteEnable,
    output logic             idExFlush,
    output logic             misaligned,
    output logic             timeoutError,
    output logic [CNT_W-1:0] stallCount
);

    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

    logic [1:0]       state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             req_q, req_d;
    logic [3:0]       we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             is_load_q, is_load_d;
    logic [31:0]      load_data_q, load_data_d;
    logic             misaligned_q, misaligned_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic access;
    logic misalign;
    logic mem_stall;
    logic hazard_stall;

    hazard_detect u_hazard_detect (
        .id_ex_mem_to_reg    (idExMemToReg),
        .id_ex_write_register(idExWriteRegister),
        .if_id_rs            (ifIdRs),
        .if_id_rt            (ifIdRt),
        .hazard_stall        (hazard_stall)
    );

    always_comb begin
        access    = memToReg | (|memWrite);
        misalign  = access & addr_misaligned(memReadWidth, aluOut[1:0]);
        mem_stall = ((state_q == StIdle) & access) | (state_q == StAccess);
    end

    always_comb begin
        pcWriteEnable    = ~(mem_stall | hazard_stall);
        ifIdWriteEnable  = ~(mem_stall | hazard_stall);
        exMemWriteEnable = ~mem_stall;
        // A memory stall freezes ID/EX; flushing it then would lose the instruction.
        idExFlush        = hazard_stall & ~mem_stall;
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        is_load_d    = is_load_q;
        load_data_d  = load_data_q;
        misaligned_d = misaligned_q;
        timeout_d    = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (misalign) begin
                    misaligned_d = 1'b1;
                    state_d      = StDone;
                end else if (access) begin
                    req_d     = 1'b1;
                    we_d      = memToReg ? 4'b0000 : memWrite;
                    addr_d    = aluOut;
                    wdata_d   = writeData;
                    is_load_d = memToReg;
                    wait_d    = '0;
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                // An acknowledge on the final wait cycle still completes the access.
                if (memReady) begin
                    if (is_load_q) begin
                        load_data_d = memRdata;
                    end
                    req_d   = 1'b0;
                    we_d    = 4'b0000;
                    state_d = StDone;
                end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    req_d     = 1'b0;
                    state_d   = StDone;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((mem_stall | hazard_stall) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            wait_q       <= '0;
            req_q        <= 1'b0;
            we_q         <= 4'b0000;
            addr_q       <= '0;
            wdata_q      <= '0;
            is_load_q    <= 1'b0;
            load_data_q  <= '0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            is_load_q    <= is_load_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
            cnt_q        <= cnt_d;
        end
    end

    assign memReq       = req_q;
    assign memWe        = we_q;
    assign memAddr      = addr_q;
    assign memWdata     = wdata_q;
    assign loadDataOut  = load_data_q;
    assign misaligned   = misaligned_q;
    assign timeoutError = timeout_q;
    assign stallCount   = cnt_q;

endmodule

// File: tb/tb_mem_stage_controller.sv
// Directed self-checking bench for mem_stage_controller: stores, loads, misalignment,
// timeout boundary, load-use hazards and asynchronous reset during an access.
module tb_mem_stage_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  memWrite;
    logic        memToReg;
    logic [1:0]  memReadWidth;
    logic [31:0] aluOut;
    logic [31:0] writeData;
    logic        idExMemToReg;
    logic [4:0]  idExWriteRegister;
    logic [4:0]  ifIdRs;
    logic [4:0]  ifIdRt;
    logic        memReady;
    logic [31:0] memRdata;
    logic        memReq;
    logic [3:0]  memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] loadDataOut;
    logic        pcWriteEnable;
    logic        ifIdWriteEnable;
    logic        exMemWriteEnable;
    logic        idExFlush;
    logic        misaligned;
    logic        timeoutError;
    logic [15:0] stallCount;

    int n_checks = 0;
    int n_fail   = 0;
    int req_cycles;

    always #5 clock = ~clock;

    mem_stage_controller #(
        .TIMEOUT(64),
        .CNT_W  (16)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .memWrite         (memWrite),
        .memToReg         (memToReg),
        .memReadWidth     (memReadWidth),
        .aluOut           (aluOut),
        .writeData        (writeData),
        .idExMemToReg     (idExMemToReg),
        .idExWriteRegister(idExWriteRegister),
        .ifIdRs           (ifIdRs),
        .ifIdRt           (ifIdRt),
        .memReady         (memReady),
        .memRdata         (memRdata),
        .memReq           (memReq),
        .memWe            (memWe),
        .memAddr          (memAddr),
        .memWdata         (memWdata),
        .loadDataOut      (loadDataOut),
        .pcWriteEnable    (pcWriteEnable),
        .ifIdWriteEnable  (ifIdWriteEnable),
        .exMemWriteEnable (exMemWriteEnable),
        .idExFlush        (idExFlush),
        .misaligned       (misaligned),
        .timeoutError     (timeoutError),
        .stallCount       (stallCount)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset             = 1'b0;
        memWrite          = 4'h0;
        memToReg          = 1'b0;
        memReadWidth      = 2'b00;
        aluOut            = 32'h0;
        writeData         = 32'h0;
        idExMemToReg      = 1'b0;
        idExWriteRegister = 5'd0;
        ifIdRs            = 5'd0;
        ifIdRt            = 5'd0;
        memReady          = 1'b0;
        memRdata          = 32'h0;
        #12;
        check_eq("rst_req", 32'(memReq), 32'h0);
        check_eq("rst_we", 32'(memWe), 32'h0);
        check_eq("rst_addr", memAddr, 32'h0);
        check_eq("rst_load", loadDataOut, 32'h0);
        check_eq("rst_cnt", 32'(stallCount), 32'h0);
        check_eq("rst_mis", 32'(misaligned), 32'h0);
        check_eq("rst_tmo", 32'(timeoutError), 32'h0);
        check_eq("rst_pcwe", 32'(pcWriteEnable), 32'h1);
        check_eq("rst_flush", 32'(idExFlush), 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // Store, ack on the third ACCESS cycle: 4 frozen cycles then DONE
        @(negedge clock);
        memWrite  = 4'hF;
        aluOut    = 32'h100;
        writeData = 32'hDEADBEEF;
        #1;
        check_eq("st_idle_stall", 32'(exMemWriteEnable), 32'h0);
        check_eq("st_idle_req", 32'(memReq), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (i == 2) memReady = 1'b1;
            #1;
            check_eq("st_req", 32'(memReq), 32'h1);
            check_eq("st_addr", memAddr, 32'h100);
            check_eq("st_we", 32'(memWe), 32'hF);
            check_eq("st_wdata", memWdata, 32'hDEADBEEF);
            check_eq("st_stall", 32'(exMemWriteEnable), 32'h0);
        end
        @(negedge clock);
        memReady = 1'b0;
        memWrite = 4'h0;
        #1;
        check_eq("st_done_adv", 32'(exMemWriteEnable), 32'h1);
        check_eq("st_done_req", 32'(memReq), 32'h0);
        check_eq("st_done_we", 32'(memWe), 32'h0);
        check_eq("st_cnt", 32'(stallCount), 32'd4);

        // Word load, ack after 1 cycle
        @(negedge clock);
        memToReg = 1'b1;
        aluOut   = 32'h204;
        memRdata = 32'h12345678;
        #1;
        check_eq("ld_idle_stall", 32'(exMemWriteEnable), 32'h0);
        @(negedge clock);
        memReady = 1'b1;
        #1;
        check_eq("ld_req", 32'(memReq), 32'h1);
        check_eq("ld_we", 32'(memWe), 32'h0);
        check_eq("ld_addr", memAddr, 32'h204);
        @(negedge clock);
        memReady = 1'b0;
        memToReg = 1'b0;
        memRdata = 32'h0;
        #1;
        check_eq("ld_data", loadDataOut, 32'h12345678);
        check_eq("ld_done_adv", 32'(exMemWriteEnable), 32'h1);
        check_eq("ld_cnt", 32'(stallCount), 32'd6);

        // Misaligned word load: one stall, no request, sticky flag
        @(negedge clock);
        memToReg = 1'b1;
        aluOut   = 32'h202;
        #1;
        check_eq("mis_stall", 32'(exMemWriteEnable), 32'h0);
        @(negedge clock);
        memToReg = 1'b0;
        #1;
        check_eq("mis_req", 32'(memReq), 32'h0);
        check_eq("mis_flag", 32'(misaligned), 32'h1);
        check_eq("mis_done_adv", 32'(exMemWriteEnable), 32'h1);
        check_eq("mis_cnt", 32'(stallCount), 32'd7);
        @(negedge clock);
        #1;
        check_eq("mis_sticky", 32'(misaligned), 32'h1);
        check_eq("mis_req2", 32'(memReq), 32'h0);

        // Ack on the 64th ACCESS cycle must win over the timeout
        @(negedge clock);
        memToReg = 1'b1;
        aluOut   = 32'h300;
        memRdata = 32'hCAFEF00D;
        for (int i = 0; i < 63; i++) @(negedge clock);
        @(negedge clock);
        memReady = 1'b1;
        #1;
        check_eq("edge_req", 32'(memReq), 32'h1);
        @(negedge clock);
        memReady = 1'b0;
        memToReg = 1'b0;
        #1;
        check_eq("edge_tmo", 32'(timeoutError), 32'h0);
        check_eq("edge_data", loadDataOut, 32'hCAFEF00D);
        check_eq("edge_req_off", 32'(memReq), 32'h0);
        check_eq("edge_cnt", 32'(stallCount), 32'd72);

        // No ack at all: request held exactly 64 cycles, then timeout
        @(negedge clock);
        memToReg   = 1'b1;
        aluOut     = 32'h400;
        req_cycles = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clock);
            #1;
            if (memReq) req_cycles++;
            else memToReg = 1'b0;
        end
        check_eq("tmo_req_cycles", 32'(req_cycles), 32'd64);
        check_eq("tmo_flag", 32'(timeoutError), 32'h1);
        check_eq("tmo_data_kept", loadDataOut, 32'hCAFEF00D);
        check_eq("tmo_cnt", 32'(stallCount), 32'd137);
        // Back in IDLE: a new load is accepted and completes
        @(negedge clock);
        memToReg = 1'b1;
        aluOut   = 32'h500;
        memRdata = 32'h0BADF00D;
        #1;
        check_eq("tmo_idle_stall", 32'(exMemWriteEnable), 32'h0);
        @(negedge clock);
        memReady = 1'b1;
        #1;
        check_eq("tmo_idle_req", 32'(memReq), 32'h1);
        @(negedge clock);
        memReady = 1'b0;
        memToReg = 1'b0;
        #1;
        check_eq("tmo_next_data", loadDataOut, 32'h0BADF00D);
        check_eq("tmo_sticky", 32'(timeoutError), 32'h1);
        check_eq("tmo_next_cnt", 32'(stallCount), 32'd139);

        // Load-use hazard on rt, cleared after the flush
        @(negedge clock);
        idExMemToReg      = 1'b1;
        idExWriteRegister = 5'd5;
        ifIdRs            = 5'd3;
        ifIdRt            = 5'd5;
        #1;
        check_eq("hz_pcwe", 32'(pcWriteEnable), 32'h0);
        check_eq("hz_ifidwe", 32'(ifIdWriteEnable), 32'h0);
        check_eq("hz_flush", 32'(idExFlush), 32'h1);
        check_eq("hz_exmem", 32'(exMemWriteEnable), 32'h1);
        @(negedge clock);
        idExMemToReg = 1'b0;
        #1;
        check_eq("hz_clear_pcwe", 32'(pcWriteEnable), 32'h1);
        check_eq("hz_clear_flush", 32'(idExFlush), 32'h0);
        check_eq("hz_cnt", 32'(stallCount), 32'd140);
        // Hazard on rs
        @(negedge clock);
        idExMemToReg      = 1'b1;
        idExWriteRegister = 5'd7;
        ifIdRs            = 5'd7;
        ifIdRt            = 5'd0;
        #1;
        check_eq("hz_rs_ifidwe", 32'(ifIdWriteEnable), 32'h0);
        check_eq("hz_rs_flush", 32'(idExFlush), 32'h1);
        // Destination r0 never stalls
        @(negedge clock);
        idExWriteRegister = 5'd0;
        ifIdRs            = 5'd0;
        ifIdRt            = 5'd0;
        #1;
        check_eq("hz_r0_pcwe", 32'(pcWriteEnable), 32'h1);
        check_eq("hz_r0_flush", 32'(idExFlush), 32'h0);
        check_eq("hz_r0_cnt", 32'(stallCount), 32'd141);
        // Hazard coinciding with a memory stall freezes rather than flushes
        @(negedge clock);
        idExWriteRegister = 5'd9;
        ifIdRt            = 5'd9;
        memWrite          = 4'h1;
        aluOut            = 32'h601;
        writeData         = 32'h55;
        memReadWidth      = 2'b10;
        #1;
        check_eq("hzm_flush", 32'(idExFlush), 32'h0);
        check_eq("hzm_pcwe", 32'(pcWriteEnable), 32'h0);
        check_eq("hzm_exmem", 32'(exMemWriteEnable), 32'h0);
        @(negedge clock);
        idExMemToReg = 1'b0;
        memReady     = 1'b1;
        #1;
        check_eq("hzm_we", 32'(memWe), 32'h1);
        check_eq("hzm_addr", memAddr, 32'h601);
        @(negedge clock);
        memReady     = 1'b0;
        memWrite     = 4'h0;
        memReadWidth = 2'b00;
        #1;
        check_eq("hzm_cnt", 32'(stallCount), 32'd143);
        check_eq("hzm_mis", 32'(misaligned), 32'h1);

        // Asynchronous reset in the middle of an access
        @(negedge clock);
        memToReg = 1'b1;
        aluOut   = 32'h700;
        memRdata = 32'hFFFFFFFF;
        @(negedge clock);
        #1;
        check_eq("rstm_req_before", 32'(memReq), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rstm_req", 32'(memReq), 32'h0);
        check_eq("rstm_addr", memAddr, 32'h0);
        check_eq("rstm_cnt", 32'(stallCount), 32'h0);
        check_eq("rstm_mis", 32'(misaligned), 32'h0);
        check_eq("rstm_tmo", 32'(timeoutError), 32'h0);
        check_eq("rstm_load", loadDataOut, 32'h0);
        @(negedge clock);
        reset    = 1'b1;
        memToReg = 1'b0;
        memReady = 1'b1;
        #1;
        @(negedge clock);
        memReady = 1'b0;
        #1;
        check_eq("late_ack_load", loadDataOut, 32'h0);
        check_eq("late_ack_req", 32'(memReq), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_controller.md
# mem_stage_controller

Sequencer for the data-memory access held in the EX/MEM pipeline register. It issues a request/acknowledge transaction to a variable-latency data memory and freezes the front of the pipeline while the access is outstanding. It also detects load-use hazards between ID/EX and IF/ID and generates the per-register write-enable and flush controls. It sits between the EX/MEM register outputs, the data memory port, and the hazard inputs of PC, IF/ID, ID/EX and EX/MEM.

## Interface
- `TIMEOUT`, default 64: maximum number of ACCESS cycles to wait for `memReady`.
- `CNT_W`, default 16: width of the stall performance counter.
- `clock` in 1: single clock. The controller registers on posedge; pipeline registers sample its outputs on the following negedge.
- `reset` in 1: asynchronous, active-low.
- `memWrite` in 4: byte-write mask from EX/MEM.
- `memToReg` in 1: load flag from EX/MEM.
- `memReadWidth` in 2: access width from EX/MEM. 00 = word, 01 = half, 10 = byte, 11 = word.
- `aluOut` in 32: effective address from EX/MEM.
- `writeData` in 32: store data from EX/MEM.
- `idExMemToReg` in 1: load flag in ID/EX.
- `idExWriteRegister` in 5: destination register in ID/EX.
- `ifIdRs` in 5, `ifIdRt` in 5: source registers in IF/ID.
- `memReady` in 1: data-memory acknowledge, 1-cycle pulse.
- `memRdata` in 32: data-memory read data, valid while `memReady`=1.
- `memReq` out 1: registered memory request.
- `memWe` out 4: registered byte-write mask.
- `memAddr` out 32: registered address.
- `memWdata` out 32: registered store data.
- `loadDataOut` out 32: captured read word.
- `pcWriteEnable` out 1, `ifIdWriteEnable` out 1, `exMemWriteEnable` out 1: register-advance enables.
- `idExFlush` out 1: zeroes the ID/EX control fields.
- `misaligned` out 1: sticky flag.
- `timeoutError` out 1: sticky flag.
- `stallCount` out CNT_W: stall performance counter.

## Operation
- `access` = `memToReg` | (|`memWrite`).
- `misalign` = `access` & ((width word & `aluOut[1:0]`≠0) | (width half & `aluOut[0]`)).
- States and transitions:
  - IDLE: if `access` & ~`misalign`, latch addr/wdata/we (we = 0 for loads), set `memReq`=1 and go to ACCESS. If `misalign`, set `misaligned`=1, issue no request, and go to DONE. Otherwise stay in IDLE.
  - ACCESS: `memReq` holds 1 and the wait counter increments.
    - `memReady`=1: capture `memRdata` into `loadDataOut` (loads only), clear `memReq`/`memWe`, go to DONE.
    - Counter reaches TIMEOUT-1 without `memReady`: set `timeoutError`=1, clear `memReq`, go to DONE.
  - DONE: always goes to IDLE next cycle. This is the cycle in which EX/MEM is allowed to advance.
- `memStall` = (IDLE & `access`) | ACCESS. This is combinational.
- `hazardStall` = `idExMemToReg` & `idExWriteRegister`≠0 & (`idExWriteRegister`==`ifIdRs` | `idExWriteRegister`==`ifIdRt`).
- `pcWriteEnable` = `ifIdWriteEnable` = ~(`memStall` | `hazardStall`).
- `exMemWriteEnable` = ~`memStall`.
- `idExFlush` = `hazardStall` & ~`memStall`. During a memory stall, ID/EX is frozen, not flushed.
- `stallCount` increments, saturating at all-ones, on every cycle with `memStall` | `hazardStall`.
- Reset values: state IDLE, wait counter 0, and every registered output 0 (`memReq`, `memWe`, `memAddr`, `memWdata`, `loadDataOut`, `misaligned`, `timeoutError`, `stallCount`).
- Reset asserted mid-ACCESS drops `memReq` immediately. A late `memReady` arriving in IDLE is ignored.

## Timing
- Access with a memory latency of N cycles, where N = cycles from `memReq` rise to `memReady`, N ≥ 1:
  - IDLE detect: 1 cycle.
  - ACCESS: N cycles.
  - DONE: 1 cycle.
  - Total: pipeline frozen N+1 cycles.
- `loadDataOut` is valid from the DONE cycle and is held until the next load completes.
- Back-to-back accesses: the instruction loaded into EX/MEM during DONE is evaluated in the following IDLE cycle. The minimum spacing between two `memReq` rising edges is N+2 cycles.
- `memReady` in the same cycle as timeout: `memReady` wins and `timeoutError` is not set.
- Misaligned access: 1 stall cycle (IDLE), then DONE. No memory traffic.
- `hazardStall` has zero latency (combinational) and lasts exactly 1 cycle once ID/EX is flushed.

## Structure
- Shared package `pipeline_pkg`: the state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the memReadWidth codes.
- One natural sub-module: `hazard_detect`, a combinational load-use compare producing `hazardStall`.
- FSM, wait counter, capture registers and performance counter all live in the top module.

## Test plan
- Store with `memWrite`=4'b1111, `aluOut`=0x100, `writeData`=0xDEADBEEF, `memReady` 3 cycles after request:
  - `memAddr`=0x100, `memWe`=4'hF, `memWdata`=0xDEADBEEF.
  - `exMemWriteEnable`=0 for 4 cycles, then 1 in DONE.
  - `stallCount`=4.
- Load with `aluOut`=0x204 and `memRdata`=0x12345678 on ack after 1 cycle:
  - `memWe`=0.
  - `loadDataOut`=0x12345678 in DONE.
  - 2 stall cycles.
- Word load at `aluOut`=0x202:
  - `memReq` never rises.
  - `misaligned`=1 (sticky).
  - 1 stall cycle.
- No `memReady` with TIMEOUT=64:
  - `memReq` high exactly 64 cycles.
  - `timeoutError`=1.
  - FSM returns to IDLE.
- `idExMemToReg`=1, `idExWriteRegister`=5, `ifIdRt`=5, no memory access:
  - `pcWriteEnable`=`ifIdWriteEnable`=0 and `idExFlush`=1 for 1 cycle.
  - Same case with `idExWriteRegister`=0 produces no stall.
- Reset pulled low during ACCESS:
  - All outputs return to 0 asynchronously.
  - `memReady` arriving afterwards leaves `loadDataOut`=0.
